fsm_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among `N` requesters. It is built as a three-state FSM with registered state and Moore-style grant outputs. It sits between the requesting FSM blocks and the shared datapath, and drives a one-hot grant plus the owner index that selects the resource's input mux. A hold-time limit forcibly revokes a grant so a stuck requester cannot starve the others.

---
 rtl/fsm_rr_arbiter_pkg.sv | 14 +
 rtl/fsm_rr_arbiter_rr_pick.sv | 29 ++
 rtl/fsm_rr_arbiter.sv | 111 +++++++++++
 tb/tb_fsm_rr_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_rr_arbiter_pkg.sv
// Shared types and default constants for the round-robin arbiter.
package arb_pkg;

   // Arbiter FSM states: idle, owner holding the grant, one-cycle release gap
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_REL   = 2'd2
   } state_type;

   localparam int unsigned ARB_N        = 4;
   localparam int unsigned ARB_HOLD_MAX = 16;

endpackage

// File: rtl/fsm_rr_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping N-1 -> 0.
module rr_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);

   localparam int unsigned IDW = $clog2(N);

   int unsigned pos;

   // Scan N positions starting at ptr; the first asserted request wins
   always_comb begin
      any = 1'b0;
      idx = '0;
      pos = 0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = (int'(ptr) + k) % N;
         if (!any && req[pos]) begin
            any = 1'b1;
            idx = IDW'(pos);
         end
      end
   end

endmodule

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter FSM with hold-time revoke and Moore-style grant outputs.
module fsm_rr_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned N        = ARB_N,
   parameter int unsigned HOLD_MAX = ARB_HOLD_MAX
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic                 timeout
);

   localparam int unsigned IDW = $clog2(N);
   localparam int unsigned HW  = $clog2(HOLD_MAX + 1);

   state_type      state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] owner_q, owner_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic           to_flag_q, to_flag_d;

   logic [IDW-1:0] pick_idx;
   logic           pick_any;
   logic [IDW-1:0] next_ptr;

   // Single picker shared by S_IDLE and S_REL, always looking from ptr_q
   rr_pick #(
      .N (N)
   ) u_pick (
      .req (req),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   // State and data registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         hold_q    <= '0;
         to_flag_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         hold_q    <= hold_d;
         to_flag_q <= to_flag_d;
      end
   end

   // Next-state logic plus output decode from registered state only
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      hold_d    = hold_q;
      to_flag_d = 1'b0;
      gnt       = '0;
      gnt_id    = '0;
      busy      = 1'b0;
      timeout   = 1'b0;

      next_ptr = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);

      unique case (state_q)
         S_IDLE: begin
            if (pick_any) begin
               owner_d = pick_idx;
               hold_d  = '0;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            gnt    = N'(1) << owner_q;
            gnt_id = owner_q;
            busy   = 1'b1;
            hold_d = hold_q + HW'(1);
            // A drop in the expiry cycle is a normal release, so test req first
            if (!req[owner_q]) begin
               state_d   = S_REL;
               to_flag_d = 1'b0;
               ptr_d     = next_ptr;
            end else if (hold_q == HW'(HOLD_MAX - 1)) begin
               state_d   = S_REL;
               to_flag_d = 1'b1;
               ptr_d     = next_ptr;
            end
         end
         S_REL: begin
            timeout = to_flag_q;
            if (pick_any) begin
               owner_d = pick_idx;
               hold_d  = '0;
               state_d = S_GRANT;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Self-checking bench for fsm_rr_arbiter: vector table, corner sequences, random vs model.
module tb_fsm_rr_arbiter;

   localparam int NR   = 4;
   localparam int HOLD = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [NR-1:0] req;
   logic [NR-1:0] gnt;
   logic [1:0]    gnt_id;
   logic          busy;
   logic          timeout;

   int errors = 0;
   int checks = 0;

   // Behavioural model: owner (-1 = nobody), cycles held, priority start, gap flag
   int m_owner;
   int m_cnt;
   int m_ptr;
   bit m_gap;
   bit m_to;

   fsm_rr_arbiter #(
      .N        (NR),
      .HOLD_MAX (HOLD)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         rst;
      logic [3:0] r;
      logic [3:0] g;
      logic [1:0] id;
      bit         b;
      bit         t;
   } vec_t;

   vec_t tbl[18];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < NR; k++) begin
         if (r[(p + k) % NR]) return (p + k) % NR;
      end
      return -1;
   endfunction

   function automatic void model_step(input bit rst, input logic [3:0] r);
      int w;
      if (rst) begin
         m_owner = -1; m_cnt = 0; m_ptr = 0; m_gap = 0; m_to = 0;
         return;
      end
      if (m_owner >= 0) begin
         if (!r[m_owner] || m_cnt == HOLD) begin
            m_to    = r[m_owner];
            m_gap   = 1;
            m_ptr   = (m_owner + 1) % NR;
            m_owner = -1;
         end else begin
            m_cnt++;
         end
      end else begin
         m_gap = 0;
         m_to  = 0;
         w = pick(r, m_ptr);
         if (w >= 0) begin
            m_owner = w;
            m_cnt   = 1;
         end
      end
   endfunction

   function automatic logic [31:0] model_out();
      logic [3:0] g;
      logic [1:0] id;
      g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      return {24'd0, g, id, (m_owner >= 0), (m_gap && m_to)};
   endfunction

   function automatic logic [31:0] dut_out();
      return {24'd0, gnt, gnt_id, busy, timeout};
   endfunction

   // One clock: drive inputs, take the edge, advance model, compare after settling
   task automatic step(input bit rst, input logic [3:0] r);
      reset = rst;
      req   = r;
      @(posedge clk);
      model_step(rst, r);
      #1;
      chk("model", dut_out(), model_out());
   endtask

   initial begin
      int hits;
      logic [3:0] r;

      reset = 1'b1;
      req   = '0;
      model_step(1'b1, 4'b0000);

      // reset, first grant, release with wrap, non-preemption
      tbl[0]  = '{1, 4'b0000, 4'b0000, 2'd0, 0, 0};
      tbl[1]  = '{1, 4'b0000, 4'b0000, 2'd0, 0, 0};
      tbl[2]  = '{0, 4'b0001, 4'b0001, 2'd0, 1, 0};
      tbl[3]  = '{0, 4'b0000, 4'b0000, 2'd0, 0, 0};
      tbl[4]  = '{0, 4'b1000, 4'b1000, 2'd3, 1, 0};
      tbl[5]  = '{0, 4'b1101, 4'b1000, 2'd3, 1, 0};
      tbl[6]  = '{0, 4'b1101, 4'b1000, 2'd3, 1, 0};
      tbl[7]  = '{0, 4'b0101, 4'b0000, 2'd0, 0, 0};
      tbl[8]  = '{0, 4'b0101, 4'b0001, 2'd0, 1, 0};
      tbl[9]  = '{0, 4'b0000, 4'b0000, 2'd0, 0, 0};
      tbl[10] = '{0, 4'b0000, 4'b0000, 2'd0, 0, 0};
      tbl[11] = '{0, 4'b0010, 4'b0010, 2'd1, 1, 0};
      tbl[12] = '{0, 4'b1010, 4'b0010, 2'd1, 1, 0};
      tbl[13] = '{0, 4'b1010, 4'b0010, 2'd1, 1, 0};
      tbl[14] = '{0, 4'b1000, 4'b0000, 2'd0, 0, 0};
      tbl[15] = '{0, 4'b1000, 4'b1000, 2'd3, 1, 0};
      tbl[16] = '{0, 4'b0000, 4'b0000, 2'd0, 0, 0};
      tbl[17] = '{0, 4'b0000, 4'b0000, 2'd0, 0, 0};

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].rst, tbl[i].r);
         chk($sformatf("vec%0d", i), dut_out(),
             {24'd0, tbl[i].g, tbl[i].id, tbl[i].b, tbl[i].t});
      end

      // Saturation: each requester in turn for HOLD cycles, then a timeout gap
      for (int g = 0; g < NR; g++) begin
         hits = 0;
         for (int c = 0; c < HOLD; c++) begin
            step(1'b0, 4'b1111);
            if (gnt === (4'b0001 << g)) hits++;
         end
         chk($sformatf("sat_len%0d", g), hits, HOLD);
         step(1'b0, 4'b1111);
         chk($sformatf("sat_gap%0d", g), {gnt, timeout}, {4'b0000, 1'b1});
      end
      step(1'b0, 4'b0001);
      chk("sat_wrap", gnt, 4'b0001);

      // Drop coinciding with expiry: normal release, no timeout
      for (int c = 0; c < HOLD - 1; c++) step(1'b0, 4'b0001);
      chk("exp_last", gnt, 4'b0001);
      step(1'b0, 4'b0000);
      chk("exp_drop", {gnt, busy, timeout}, 6'b000000);
      step(1'b0, 4'b0000);
      chk("exp_idle", {gnt, timeout}, 5'b00000);

      // Reset while owner 2 holds the grant
      step(1'b0, 4'b1101);
      chk("rst_own2", gnt, 4'b0100);
      step(1'b0, 4'b1101);
      step(1'b1, 4'b1101);
      chk("rst_mid", {gnt, gnt_id, busy, timeout}, 8'h00);
      step(1'b0, 4'b1101);
      chk("rst_ptr0", {gnt, gnt_id}, {4'b0001, 2'd0});

      // Random traffic with sticky requests and rare resets
      r = 4'b0000;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         step($urandom_range(0, 99) == 0, r);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
